// File: rtl/mem_refill_arbiter.sv
// Round-robin arbiter sharing one 16B-line memory port among p_num_reqs cache banks;
// an in-order ID FIFO steers responses back. Optional: MEM_REFILL_ARBITER_OPAQUE_CHECK_EN.
module mem_refill_arbiter #(
  parameter int p_num_reqs        = 4,
  parameter int p_max_outstanding = 4,
  // mem_req_16B_t  = {type[2:0], opaque[7:0], addr[31:0], len[3:0], data[127:0]}
  // mem_resp_16B_t = {type[2:0], opaque[7:0], test[1:0], len[3:0], data[127:0]}
  localparam int c_req_nbits  = 175,
  localparam int c_resp_nbits = 145
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [p_num_reqs*c_req_nbits-1:0]    req_msg,
  input  logic [p_num_reqs-1:0]                req_val,
  output logic [p_num_reqs-1:0]                req_rdy,
  output logic [p_num_reqs*c_resp_nbits-1:0]   resp_msg,
  output logic [p_num_reqs-1:0]                resp_val,
  input  logic [p_num_reqs-1:0]                resp_rdy,
  output logic [c_req_nbits-1:0]               memreq_msg,
  output logic                                 memreq_val,
  input  logic                                 memreq_rdy,
  input  logic [c_resp_nbits-1:0]              memresp_msg,
  input  logic                                 memresp_val,
  output logic                                 memresp_rdy,
  output logic                                 opaque_err
);

  localparam int c_id_nbits  = $clog2(p_num_reqs);
  localparam int c_ptr_nbits = $clog2(p_max_outstanding);
  localparam int c_cnt_nbits = c_ptr_nbits + 1;
  localparam logic [c_cnt_nbits-1:0] c_depth = c_cnt_nbits'(p_max_outstanding);

  logic [c_id_nbits-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [c_id_nbits-1:0]  grant_id, scan_id, head_id;
  logic [p_num_reqs-1:0]  grant_oh;
  logic                   any_req;

  logic [c_ptr_nbits-1:0] head_reg, head_next, tail_reg, tail_next;
  logic [c_cnt_nbits-1:0] count_reg, count_next;
  logic                   full, empty, push, pop;

  // Read asynchronously: the head ID must steer the response in the same cycle.
  logic [c_id_nbits-1:0]  id_mem [p_max_outstanding];

  assign any_req = |req_val;
  assign full    = (count_reg == c_depth);
  assign empty   = (count_reg == '0);

  // Walk from farthest to nearest offset so the nearest requester wins.
  always_comb begin
    grant_id = rr_ptr_reg;
    scan_id  = '0;
    for (int k = p_num_reqs - 1; k >= 0; k--) begin
      scan_id = rr_ptr_reg + c_id_nbits'(k);
      if (req_val[scan_id]) begin
        grant_id = scan_id;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < p_num_reqs; gi++) begin : g_lane
      assign grant_oh[gi] = any_req && (grant_id == c_id_nbits'(gi));
      assign req_rdy[gi]  = !reset && grant_oh[gi] && memreq_rdy && !full;
      assign resp_val[gi] = !reset && memresp_val && !empty && (head_id == c_id_nbits'(gi));
      assign resp_msg[gi*c_resp_nbits +: c_resp_nbits] = memresp_msg;
    end
  endgenerate

  always_comb begin
    memreq_msg = '0;
    for (int i = 0; i < p_num_reqs; i++) begin
      memreq_msg = memreq_msg | ({c_req_nbits{grant_oh[i]}} & req_msg[i*c_req_nbits +: c_req_nbits]);
    end
  end

  assign memreq_val  = !reset && any_req && !full;
  assign head_id     = id_mem[head_reg];
  assign memresp_rdy = !reset && !empty && resp_rdy[head_id];

  assign push = memreq_val && memreq_rdy;
  assign pop  = memresp_val && memresp_rdy;

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    head_next   = head_reg;
    tail_next   = tail_reg;
    count_next  = count_reg;
    if (push) begin
      rr_ptr_next = grant_id + c_id_nbits'(1);
      tail_next   = tail_reg + c_ptr_nbits'(1);
    end
    if (pop) begin
      head_next = head_reg + c_ptr_nbits'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + c_cnt_nbits'(1);
      2'b01:   count_next = count_reg - c_cnt_nbits'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg <= '0;
      head_reg   <= '0;
      tail_reg   <= '0;
      count_reg  <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      head_reg   <= head_next;
      tail_reg   <= tail_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[tail_reg] <= grant_id;
    end
  end

`ifdef MEM_REFILL_ARBITER_OPAQUE_CHECK_EN
  localparam int c_req_opq_lsb  = 164;
  localparam int c_resp_opq_lsb = 134;

  logic [7:0] opq_mem [p_max_outstanding];
  logic [7:0] head_opq, resp_opq;
  logic       opq_mismatch;
  logic       opaque_err_reg, opaque_err_next;

  always_ff @(posedge clk) begin
    if (push) begin
      opq_mem[tail_reg] <= memreq_msg[c_req_opq_lsb +: 8];
    end
  end

  assign head_opq        = opq_mem[head_reg];
  assign resp_opq        = memresp_msg[c_resp_opq_lsb +: 8];
  assign opq_mismatch    = pop && (resp_opq != head_opq);
  assign opaque_err_next = opaque_err_reg | opq_mismatch;

  always_ff @(posedge clk) begin
    if (reset) begin
      opaque_err_reg <= 1'b0;
    end else begin
      opaque_err_reg <= opaque_err_next;
    end
  end

  assign opaque_err = opaque_err_reg;

`ifndef SYNTHESIS
  logic [31:0] cycle_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_reg <= '0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && opq_mismatch) begin
      $display("mem_refill_arbiter: opaque mismatch cycle=%0d head_id=%0d issued=%02h returned=%02h",
               cycle_cnt_reg, head_id, head_opq, resp_opq);
    end
  end
`endif
`else
  assign opaque_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Bench for mem_refill_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based model of the arbiter and an in-order memory.
module tb_mem_refill_arbiter;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int RQW   = 175;
  localparam int RSW   = 145;
`ifdef MEM_REFILL_ARBITER_OPAQUE_CHECK_EN
  localparam bit OPQ_EN = 1'b1;
`else
  localparam bit OPQ_EN = 1'b0;
`endif

  logic               clk;
  logic               reset;
  logic [N*RQW-1:0]   req_msg;
  logic [N-1:0]       req_val;
  logic [N-1:0]       req_rdy;
  logic [N*RSW-1:0]   resp_msg;
  logic [N-1:0]       resp_val;
  logic [N-1:0]       resp_rdy;
  logic [RQW-1:0]     memreq_msg;
  logic               memreq_val;
  logic               memreq_rdy;
  logic [RSW-1:0]     memresp_msg;
  logic               memresp_val;
  logic               memresp_rdy;
  logic               opaque_err;

  mem_refill_arbiter #(.p_num_reqs(N), .p_max_outstanding(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_msg(req_msg), .req_val(req_val), .req_rdy(req_rdy),
    .resp_msg(resp_msg), .resp_val(resp_val), .resp_rdy(resp_rdy),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
    .opaque_err(opaque_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: issuer IDs in flight, round-robin start, memory request queue.
  int          q[$];
  int          rr;
  bit          exp_err;
  logic [31:0] mq_addr[$];
  logic [7:0]  mq_opq[$];
  int          mem_mode;  // 0: silent, 1: respond whenever pending, 2: respond randomly
  bit          corrupt;

  logic [N-1:0] last_req_rdy, last_resp_val;
  logic         last_memresp_rdy, last_err;

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RQW-1:0] mk_req(input logic [7:0] opq, input logic [31:0] addr);
    return {3'd0, opq, addr, 4'd0, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [RSW-1:0] mk_resp(input logic [7:0] opq, input logic [31:0] addr);
    return {3'd0, opq, 2'd0, 4'd0, addr, addr, addr, addr};
  endfunction

  // One cycle: drive memory side, check every output against the model, advance the model.
  task automatic step();
    int             g;
    int             j;
    bit             full, empty, e_mrq_val, e_mrs_rdy, push, pop;
    logic [N-1:0]   e_req_rdy, e_resp_val;
    logic [RQW-1:0] lane;
    if (mq_addr.size() > 0)
      memresp_msg = mk_resp(corrupt ? mq_opq[0] + 8'd1 : mq_opq[0], mq_addr[0]);
    else
      memresp_msg = mk_resp(8'($urandom), $urandom);
    case (mem_mode)
      1:       memresp_val = (mq_addr.size() > 0);
      2:       memresp_val = (mq_addr.size() > 0) && ($urandom_range(1, 0) == 1);
      default: memresp_val = 1'b0;
    endcase
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      j = (rr + k) % N;
      if (g < 0 && req_val[j]) g = j;
    end
    full       = (q.size() == DEPTH);
    empty      = (q.size() == 0);
    e_mrq_val  = (g >= 0) && !full;
    e_req_rdy  = (e_mrq_val && memreq_rdy) ? (N'(1) << g) : '0;
    e_mrs_rdy  = !empty && resp_rdy[empty ? 0 : q[0]];
    e_resp_val = (memresp_val && !empty) ? (N'(1) << q[0]) : '0;
    chk("memreq_val", memreq_val, e_mrq_val);
    chk("req_rdy", req_rdy, e_req_rdy);
    chk("memresp_rdy", memresp_rdy, e_mrs_rdy);
    chk("resp_val", resp_val, e_resp_val);
    chk("resp_msg", resp_msg, {N{memresp_msg}});
    chk("opaque_err", opaque_err, exp_err);
    if (e_mrq_val) chk("memreq_msg", memreq_msg, req_msg[g*RQW +: RQW]);
    last_req_rdy     = req_rdy;
    last_resp_val    = resp_val;
    last_memresp_rdy = memresp_rdy;
    last_err         = opaque_err;
    push = e_mrq_val && memreq_rdy;
    pop  = memresp_val && e_mrs_rdy;
    if (pop) begin
      chk("resp_data", resp_msg[q[0]*RSW +: 128], {4{mq_addr[0]}});
      if (corrupt && OPQ_EN) exp_err = 1'b1;
      void'(q.pop_front());
      void'(mq_addr.pop_front());
      void'(mq_opq.pop_front());
    end
    if (push) begin
      lane = req_msg[g*RQW +: RQW];
      q.push_back(g);
      rr = (g + 1) % N;
      mq_addr.push_back(lane[163:132]);
      mq_opq.push_back(lane[171:164]);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input bit clear_mem);
    reset       = 1'b1;
    req_val     = '1;
    resp_rdy    = '1;
    memreq_rdy  = 1'b1;
    memresp_val = 1'b1;
    #1;
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_memreq_val", memreq_val, 0);
    chk("rst_memresp_rdy", memresp_rdy, 0);
    chk("rst_resp_val", resp_val, 0);
    @(posedge clk);
    q.delete();
    rr      = 0;
    exp_err = 1'b0;
    if (clear_mem) begin
      mq_addr.delete();
      mq_opq.delete();
    end
    @(negedge clk);
    reset       = 1'b0;
    req_val     = '0;
    memresp_val = 1'b0;
    #1;
    chk("rst_opaque_err", opaque_err, 0);
  endtask

  task automatic set_lane(input int b, input logic [7:0] opq, input logic [31:0] addr);
    req_msg[b*RQW +: RQW] = mk_req(opq, addr);
  endtask

  int order[5] = '{0, 1, 2, 3, 0};

  initial begin
    reset = 1'b1; req_val = '0; req_msg = '0; resp_rdy = '1; memreq_rdy = 1'b1;
    memresp_val = 1'b0; memresp_msg = '0; mem_mode = 0; corrupt = 1'b0;
    rr = 0; exp_err = 1'b0;
    @(negedge clk);
    do_reset(1'b1);

    // Idle after reset
    for (int c = 0; c < 10; c++) step();

    // All banks requesting, memory answers one cycle later
    mem_mode = 1;
    req_val  = '1;
    for (int k = 0; k < 5; k++) begin
      for (int b = 0; b < N; b++) set_lane(b, 8'(k), 32'(b * 256 + k * 16));
      step();
      chk("rr_order", last_req_rdy, N'(1) << order[k]);
    end
    req_val = '0;
    for (int c = 0; c < 4; c++) step();

    // Bank 2 alone fills the FIFO; a pop frees the slot only for the next cycle
    do_reset(1'b1);
    mem_mode = 0;
    req_val  = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      set_lane(2, 8'(k), 32'h2000 + 32'(k * 16));
      step();
      chk("fill_req_rdy", last_req_rdy, (k < 4) ? 4'b0100 : 4'b0000);
    end
    mem_mode = 1;
    step();
    chk("full_pop_req_rdy", last_req_rdy, 4'b0000);
    chk("full_pop_memresp_rdy", last_memresp_rdy, 1'b1);
    mem_mode = 0;
    step();
    chk("freed_req_rdy", last_req_rdy, 4'b0100);
    req_val  = '0;
    mem_mode = 1;
    for (int c = 0; c < 6; c++) step();

    // Head-of-line blocking: bank 1 stalls, bank 3 must wait behind it
    do_reset(1'b1);
    mem_mode = 0;
    req_val  = 4'b0010; set_lane(1, 8'h11, 32'h1100); step();
    req_val  = 4'b1000; set_lane(3, 8'h33, 32'h3300); step();
    req_val  = '0;
    resp_rdy = 4'b1101;
    mem_mode = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("hol_memresp_rdy", last_memresp_rdy, 1'b0);
      chk("hol_resp_val", last_resp_val, 4'b0010);
    end
    resp_rdy = '1;
    step();
    chk("hol_first_bank1", last_resp_val, 4'b0010);
    step();
    chk("hol_then_bank3", last_resp_val, 4'b1000);

    // Reset with requests in flight, then a stale response
    do_reset(1'b1);
    mem_mode = 0;
    req_val = 4'b0010; set_lane(1, 8'h01, 32'h100); step();
    req_val = 4'b0100; set_lane(2, 8'h02, 32'h200); step();
    req_val = 4'b0010; set_lane(1, 8'h03, 32'h300); step();
    do_reset(1'b0);
    mem_mode = 1;
    step();
    chk("stale_memresp_rdy", last_memresp_rdy, 1'b0);
    chk("stale_resp_val", last_resp_val, 4'b0000);
    mq_addr.delete();
    mq_opq.delete();
    mem_mode = 0;
    req_val  = 4'b0101;
    set_lane(0, 8'h0a, 32'h0a00);
    set_lane(2, 8'h0b, 32'h0b00);
    step();
    chk("post_reset_grant", last_req_rdy, 4'b0001);
    req_val  = '0;
    mem_mode = 1;
    for (int c = 0; c < 3; c++) step();

    // Opaque mismatch: issue 0x04, memory returns 0x05
    do_reset(1'b1);
    mem_mode = 0;
    req_val  = 4'b0001; set_lane(0, 8'h04, 32'h40); step();
    req_val  = '0;
    corrupt  = 1'b1;
    mem_mode = 1;
    step();
    chk("opq_err_fire_cycle", last_err, 1'b0);
    chk("opq_route", last_resp_val, 4'b0001);
    corrupt  = 1'b0;
    mem_mode = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("opq_err_sticky", last_err, OPQ_EN);
    end
    do_reset(1'b1);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      req_val = N'($urandom);
      for (int b = 0; b < N; b++) set_lane(b, 8'($urandom), $urandom);
      memreq_rdy = ($urandom_range(3, 0) != 0);
      resp_rdy   = N'($urandom);
      mem_mode   = 2;
      step();
    end
    req_val    = '0;
    resp_rdy   = '1;
    memreq_rdy = 1'b1;
    mem_mode   = 1;
    for (int c = 0; c < 8; c++) step();
    chk("drained_memresp_rdy", memresp_rdy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
